// File: rtl/vmove_pkg.sv
// Shared types and default sizing for the vector move issue scheduler.
package vmove_pkg;

  localparam int unsigned VM_NUM_REQ    = 4;
  localparam int unsigned VM_DATA_WIDTH = 64;
  localparam int unsigned VM_LATENCY    = 6;
  localparam int unsigned VM_RSP_DEPTH  = 4;

  localparam int unsigned REQ_ID_W = $clog2(VM_NUM_REQ);
  localparam int unsigned CRED_W   = $clog2(VM_RSP_DEPTH + 1);

  typedef logic [REQ_ID_W-1:0] req_id_t;
  typedef logic [CRED_W-1:0]   credit_t;

  // One tag pipe stage: valid bit plus the requester that owns the result.
  typedef struct packed {
    logic    v;
    req_id_t id;
  } tag_t;

endpackage

// File: rtl/vmove_issue_sched_if.sv
// Requester-side request/response bus of the vector move issue scheduler.
interface vmove_issue_sched_if
  import vmove_pkg::*;
#(
  parameter int unsigned NUM_REQ    = VM_NUM_REQ,
  parameter int unsigned DATA_WIDTH = VM_DATA_WIDTH
);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [NUM_REQ-1:0]            rsp_ready;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/vmove_rsp_fifo.sv
// First-word fall-through response FIFO; head data reads as zero when empty.
module vmove_rsp_fifo #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o
);

  localparam int unsigned AW = $clog2(RSP_DEPTH);

  logic [AW:0]           wptr_q, rptr_q;
  logic [DATA_WIDTH-1:0] mem_q [RSP_DEPTH];
  logic                  empty;
  logic                  do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty;
  assign valid_o = !empty;
  assign data_o  = empty ? '0 : mem_q[rptr_q[AW-1:0]];

  // Pointer update; the extra wrap bit separates full from empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push_i) wptr_q <= wptr_q + 1'b1;
      if (do_pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage write; a push into a full FIFO with a pop reuses the slot being read out.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/vmove_issue_sched.sv
// Round-robin issue of NUM_REQ requesters onto one fixed-latency vector pipe,
// with a matching tag pipe, per-requester response FIFOs and credit control.
module vmove_issue_sched
  import vmove_pkg::*;
#(
  parameter int unsigned NUM_REQ    = VM_NUM_REQ,
  parameter int unsigned DATA_WIDTH = VM_DATA_WIDTH,
  parameter int unsigned LATENCY    = VM_LATENCY,
  parameter int unsigned RSP_DEPTH  = VM_RSP_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  vmove_issue_sched_if.slave    bus,
  output logic [DATA_WIDTH-1:0] pipe_in_vec,
  output logic                  pipe_in_valid,
  input  logic [DATA_WIDTH-1:0] pipe_out_vec,
  input  logic                  pipe_out_valid,
  output logic                  busy,
  output logic                  err
);

  logic [DATA_WIDTH-1:0]         pipe_in_vec_q;
  logic                          pipe_in_valid_q;
  req_id_t                       issue_id_q;
  req_id_t                       rr_ptr_q;
  tag_t                          tag_q [LATENCY];
  credit_t                       credit_q [NUM_REQ];
  logic                          err_q;

  logic [NUM_REQ-1:0]            eligible;
  logic [NUM_REQ-1:0]            grant;
  logic                          grant_any;
  req_id_t                       grant_id;
  logic [NUM_REQ-1:0]            push;
  logic [NUM_REQ-1:0]            pop;
  logic [NUM_REQ-1:0]            fifo_full;
  logic [NUM_REQ-1:0]            rsp_valid_w;
  logic [NUM_REQ*DATA_WIDTH-1:0] rsp_data_w;
  logic                          tag_any;
  tag_t                          tag_out;

  assign tag_out = tag_q[LATENCY-1];

  // Eligibility: valid request, free credit, and not in reset.
  always_comb begin
    eligible = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      eligible[i] = !rst && bus.req_valid[i] && (credit_q[i] < credit_t'(RSP_DEPTH));
    end
  end

  // Round-robin pick of the first eligible requester at or after rr_ptr.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    idx       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_any && eligible[idx]) begin
        grant_any = 1'b1;
        grant_id  = req_id_t'(idx);
      end
    end
    if (grant_any) grant[grant_id] = 1'b1;
  end

  assign bus.req_ready = grant;

  // Retire routing and FIFO pops; a result is pushed only when pipe and tag both agree.
  always_comb begin
    push = '0;
    pop  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      push[i] = pipe_out_valid && tag_out.v && (tag_out.id == req_id_t'(i));
      pop[i]  = rsp_valid_w[i] && bus.rsp_ready[i];
    end
  end

  // Any valid tag in the tag pipe.
  always_comb begin
    tag_any = 1'b0;
    for (int unsigned k = 0; k < LATENCY; k++) begin
      tag_any = tag_any | tag_q[k].v;
    end
  end

  // Issue register, round-robin pointer, tag pipe and sticky error.
  // Tag stage 0 captures the issue register, so stage LATENCY-1 lines up with pipe_out_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_in_vec_q   <= '0;
      pipe_in_valid_q <= 1'b0;
      issue_id_q      <= '0;
      rr_ptr_q        <= '0;
      err_q           <= 1'b0;
      for (int unsigned k = 0; k < LATENCY; k++) tag_q[k] <= '0;
    end else begin
      pipe_in_valid_q <= grant_any;
      if (grant_any) begin
        pipe_in_vec_q <= bus.req_data[grant_id*DATA_WIDTH +: DATA_WIDTH];
        issue_id_q    <= grant_id;
        if (grant_id == req_id_t'(NUM_REQ - 1)) rr_ptr_q <= '0;
        else                                    rr_ptr_q <= grant_id + 1'b1;
      end
      tag_q[0] <= '{v: pipe_in_valid_q, id: issue_id_q};
      for (int unsigned k = 1; k < LATENCY; k++) tag_q[k] <= tag_q[k-1];
      if (tag_out.v != pipe_out_valid) err_q <= 1'b1;
    end
  end

  // Credits cover in-flight plus queued results; the push itself moves nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REQ; i++) credit_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        credit_q[i] <= credit_q[i] + credit_t'(grant[i]) - credit_t'(pop[i]);
      end
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_fifo
    vmove_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .RSP_DEPTH  (RSP_DEPTH)
    ) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push[gi]),
      .push_data_i (pipe_out_vec),
      .pop_i       (pop[gi]),
      .valid_o     (rsp_valid_w[gi]),
      .data_o      (rsp_data_w[gi*DATA_WIDTH +: DATA_WIDTH]),
      .full_o      (fifo_full[gi])
    );

    // Credits make a push into a full FIFO unreachable.
    assert property (@(posedge clk) disable iff (rst) !(push[gi] && fifo_full[gi] && !pop[gi]));
  end

  assign bus.rsp_valid = rsp_valid_w;
  assign bus.rsp_data  = rsp_data_w;
  assign pipe_in_vec   = pipe_in_vec_q;
  assign pipe_in_valid = pipe_in_valid_q;
  assign err           = err_q;
  // The issue register holds a tag one cycle before it enters the tag pipe.
  assign busy          = pipe_in_valid_q | tag_any | (|rsp_valid_w);

endmodule
